// File: rtl/avalon_ddr3_responder.sv
// Avalon-MM responder standing in for the DDR3 controller port (128-bit words).
// Read latency: READ_LATENCY cycles from acceptance to first readdatavalid. Write data lands at the acceptance edge.
// Backpressure: waitrequest is held high while read beats are issued.
// Optional AVS_RANDOM_WAIT_EN: an LFSR also inserts wait states in IDLE and WRITE_BURST.
module avalon_ddr3_responder #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  avs_s0_address,
  input  logic         avs_s0_read,
  input  logic         avs_s0_write,
  input  logic [127:0] avs_s0_writedata,
  input  logic [15:0]  avs_s0_byteenable,
  input  logic [6:0]   avs_s0_burstcount,
  output logic [127:0] avs_s0_readdata,
  output logic         avs_s0_readdatavalid,
  output logic         avs_s0_waitrequest,
  output logic         proto_err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WRITE_BURST = 2'd1;
  localparam logic [1:0] READ_BURST  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [6:0]        rem_q, rem_d;
  logic              proto_err_q, proto_err_d;

  logic [READ_LATENCY-1:0]        pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][127:0] pipe_dat_q, pipe_dat_d;

  logic [127:0] mem_q [DEPTH];

  logic              stall;
  logic              wait_w;
  logic [ADDR_W-1:0] cmd_idx;
  logic [6:0]        bc_eff;
  logic              issue;
  logic [ADDR_W-1:0] issue_idx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic              unused_addr;

  assign cmd_idx     = avs_s0_address[ADDR_W+3:4];
  assign bc_eff      = (avs_s0_burstcount == 7'd0) ? 7'd1 : avs_s0_burstcount;
  assign unused_addr = ^{avs_s0_address[31:ADDR_W+4], avs_s0_address[3:0]};

`ifdef AVS_RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; free-running wait-state source
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, restarts from the fixed seed on reset
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Reset also holds off commands so nothing is written while reset is high
  assign wait_w = reset | (state_q == READ_BURST) | stall;

  // Command acceptance, burst sequencing and protocol-error detection
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    proto_err_d = proto_err_q;
    issue       = 1'b0;
    issue_idx   = idx_q;
    mem_we      = 1'b0;
    mem_widx    = idx_q;
    case (state_q)
      IDLE: begin
        if (avs_s0_write && !wait_w) begin
          // A simultaneous read is dropped in favour of the write
          mem_we   = 1'b1;
          mem_widx = cmd_idx;
          idx_d    = cmd_idx + 1'b1;
          rem_d    = bc_eff - 7'd1;
          if (avs_s0_read)     proto_err_d = 1'b1;
          if (bc_eff > 7'd1)   state_d     = WRITE_BURST;
        end else if (avs_s0_read && !wait_w) begin
          issue     = 1'b1;
          issue_idx = cmd_idx;
          idx_d     = cmd_idx + 1'b1;
          rem_d     = bc_eff - 7'd1;
          if (bc_eff > 7'd1)   state_d     = READ_BURST;
        end
      end
      WRITE_BURST: begin
        if (avs_s0_read) proto_err_d = 1'b1;
        if (avs_s0_write && !wait_w) begin
          mem_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          rem_d  = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = IDLE;
        end
      end
      READ_BURST: begin
        // One beat per cycle, independent of the bus inputs
        issue = 1'b1;
        idx_d = idx_q + 1'b1;
        rem_d = rem_q - 7'd1;
        if (rem_q == 7'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return pipeline: array sampled at issue, shifted READ_LATENCY stages
  always_comb begin
    pipe_vld_d[0] = issue;
    pipe_dat_d[0] = issue ? mem_q[issue_idx] : 128'd0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  // Control and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      proto_err_q <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_dat_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      proto_err_q <= proto_err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_dat_q  <= pipe_dat_d;
    end
  end

  // Word array with per-byte write enables; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 16; b++) begin
        if (avs_s0_byteenable[b]) mem_q[mem_widx][b*8 +: 8] <= avs_s0_writedata[b*8 +: 8];
      end
    end
  end

  assign avs_s0_readdata      = pipe_dat_q[READ_LATENCY-1];
  assign avs_s0_readdatavalid = pipe_vld_q[READ_LATENCY-1];
  assign avs_s0_waitrequest   = wait_w;
  assign proto_err            = proto_err_q;

endmodule
